// File: rtl/beam_pkg.sv
// Shared constants and the per-sample scale/round/saturate helper for the beam splitter.
// Q2.7 weight times signed 8-bit sample, rounded half toward +inf, clamped to the sample range.
package beam_pkg;

    localparam int unsigned LANES       = 16;
    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned ROUND_SHIFT = 7;

    localparam logic signed [17:0] ROUND_OFFSET = 18'sd64;
    localparam logic signed [17:0] SAMPLE_MAX   = 18'sd127;
    localparam logic signed [17:0] SAMPLE_MIN   = -18'sd128;

    typedef enum logic [1:0] {
        CH00 = 2'd0,
        CH01 = 2'd1,
        CH20 = 2'd2,
        CH21 = 2'd3
    } chan_e;

    function automatic logic [7:0] scale_sample(input logic signed [8:0] w,
                                                input logic signed [7:0] s);
        logic signed [17:0] p;
        logic signed [17:0] r;
        p = 18'(w) * 18'(s);
        r = (p + ROUND_OFFSET) >>> ROUND_SHIFT;
        if (r > SAMPLE_MAX) begin
            return 8'h7F;
        end else if (r < SAMPLE_MIN) begin
            return 8'h80;
        end
        return r[7:0];
    endfunction

endpackage

// File: rtl/axi_beam_fifo2.sv
// Show-ahead FIFO used once per output channel; head is always visible on dout.
// Push while full is accepted only when a pop happens on the same edge.
module axi_beam_fifo2 #(
    parameter int WIDTH = 130,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/axi_beam_splitter.sv
// Fans one 16-lane sample stream out to four independently back-pressured channel streams,
// each scaled by its own Q2.7 weight captured at the input accept edge.
module axi_beam_splitter
    import beam_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int SAMPLE_WIDTH = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [WEIGHT_WIDTH:0] bWeight00_real,
    input  logic [WEIGHT_WIDTH:0] bWeight01_real,
    input  logic [WEIGHT_WIDTH:0] bWeight20_real,
    input  logic [WEIGHT_WIDTH:0] bWeight21_real,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [DATA_WIDTH-1:0] m00_axi_rdata,
    output logic                  m00_axi_rstrb,
    output logic                  m00_axi_rlast,
    output logic                  m00_axi_rvalid,
    input  logic                  m00_axi_rready,
    output logic [DATA_WIDTH-1:0] m01_axi_rdata,
    output logic                  m01_axi_rstrb,
    output logic                  m01_axi_rlast,
    output logic                  m01_axi_rvalid,
    input  logic                  m01_axi_rready,
    output logic [DATA_WIDTH-1:0] m20_axi_rdata,
    output logic                  m20_axi_rstrb,
    output logic                  m20_axi_rlast,
    output logic                  m20_axi_rvalid,
    input  logic                  m20_axi_rready,
    output logic [DATA_WIDTH-1:0] m21_axi_rdata,
    output logic                  m21_axi_rstrb,
    output logic                  m21_axi_rlast,
    output logic                  m21_axi_rvalid,
    input  logic                  m21_axi_rready
);

    localparam int BEAT_W = DATA_WIDTH + 2;

    logic signed [WEIGHT_WIDTH:0]     weight     [NUM_CH];
    logic [LANES-1:0][SAMPLE_WIDTH-1:0] scaled   [NUM_CH];
    logic [BEAT_W-1:0]                stage_beat [NUM_CH];
    logic [BEAT_W-1:0]                head       [NUM_CH];
    logic [NUM_CH-1:0]                fifo_full;
    logic [NUM_CH-1:0]                fifo_empty;
    logic [NUM_CH-1:0]                rready;
    logic [NUM_CH-1:0]                pop;
    logic                             run;
    logic                             stage_valid;
    logic                             all_space;
    logic                             advance;
    logic                             accept;

    assign weight[CH00] = $signed(bWeight00_real);
    assign weight[CH01] = $signed(bWeight01_real);
    assign weight[CH20] = $signed(bWeight20_real);
    assign weight[CH21] = $signed(bWeight21_real);
    assign rready       = {m21_axi_rready, m20_axi_rready, m01_axi_rready, m00_axi_rready};

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                scaled[c][l] = scale_sample(weight[c], s_axi_wdata[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
            end
        end
    end

    // The stage beat moves into every channel together or not at all, so no channel can skip or repeat it.
    assign all_space    = ~|fifo_full;
    assign advance      = stage_valid && all_space;
    assign s_axi_wready = run && (!stage_valid || all_space);
    assign accept       = s_axi_wvalid && s_axi_wready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            run         <= 1'b0;
            stage_valid <= 1'b0;
            stage_beat  <= '{default: '0};
        end else begin
            run <= 1'b1;
            if (accept) begin
                stage_valid <= 1'b1;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    stage_beat[c] <= {s_axi_wlast, s_axi_wstrb, scaled[c]};
                end
            end else if (advance) begin
                stage_valid <= 1'b0;
            end
        end
    end

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
            assign pop[gc] = !fifo_empty[gc] && rready[gc];

            axi_beam_fifo2 #(
                .WIDTH (BEAT_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clock  (clock),
                .resetn (resetn),
                .push   (advance),
                .din    (stage_beat[gc]),
                .pop    (pop[gc]),
                .dout   (head[gc]),
                .full   (fifo_full[gc]),
                .empty  (fifo_empty[gc])
            );
        end
    endgenerate

    assign m00_axi_rdata  = head[CH00][DATA_WIDTH-1:0];
    assign m00_axi_rstrb  = head[CH00][DATA_WIDTH];
    assign m00_axi_rlast  = head[CH00][DATA_WIDTH+1];
    assign m00_axi_rvalid = !fifo_empty[CH00];

    assign m01_axi_rdata  = head[CH01][DATA_WIDTH-1:0];
    assign m01_axi_rstrb  = head[CH01][DATA_WIDTH];
    assign m01_axi_rlast  = head[CH01][DATA_WIDTH+1];
    assign m01_axi_rvalid = !fifo_empty[CH01];

    assign m20_axi_rdata  = head[CH20][DATA_WIDTH-1:0];
    assign m20_axi_rstrb  = head[CH20][DATA_WIDTH];
    assign m20_axi_rlast  = head[CH20][DATA_WIDTH+1];
    assign m20_axi_rvalid = !fifo_empty[CH20];

    assign m21_axi_rdata  = head[CH21][DATA_WIDTH-1:0];
    assign m21_axi_rstrb  = head[CH21][DATA_WIDTH];
    assign m21_axi_rlast  = head[CH21][DATA_WIDTH+1];
    assign m21_axi_rvalid = !fifo_empty[CH21];

endmodule

// File: tb/tb_axi_beam_splitter.sv
// Bench for axi_beam_splitter: directed scenarios plus random traffic against a beat-list model.
module tb_axi_beam_splitter;

    localparam int DEPTH = 2;

    logic              clock  = 1'b0;
    logic              resetn = 1'b0;
    logic [3:0][8:0]   w;
    logic [127:0]      wdata;
    logic              wstrb, wlast, wvalid, wready;
    logic [3:0][127:0] rdata;
    logic [3:0]        rstrb, rlast, rvalid, rready;

    int vectors     = 0;
    int miscompares = 0;

    // Model: every accepted beat with its weights; each channel reads the list at its own index.
    logic [127:0]    bd  [4096];
    logic [3:0][8:0] bwt [4096];
    logic            bs  [4096];
    logic            bl  [4096];
    logic [127:0]    ch3_log [256];
    int acc_cnt = 0;
    int pop_idx [4];
    int pops_total [4];
    int lasts_total [4];
    bit prev_v [4];
    bit prev_pop [4];
    bit model_run = 0;

    always #5 clock = ~clock;

    axi_beam_splitter #(
        .DATA_WIDTH   (128),
        .SAMPLE_WIDTH (8),
        .WEIGHT_WIDTH (8),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .bWeight00_real (w[0]),
        .bWeight01_real (w[1]),
        .bWeight20_real (w[2]),
        .bWeight21_real (w[3]),
        .s_axi_wdata    (wdata),
        .s_axi_wstrb    (wstrb),
        .s_axi_wlast    (wlast),
        .s_axi_wvalid   (wvalid),
        .s_axi_wready   (wready),
        .m00_axi_rdata  (rdata[0]),
        .m00_axi_rstrb  (rstrb[0]),
        .m00_axi_rlast  (rlast[0]),
        .m00_axi_rvalid (rvalid[0]),
        .m00_axi_rready (rready[0]),
        .m01_axi_rdata  (rdata[1]),
        .m01_axi_rstrb  (rstrb[1]),
        .m01_axi_rlast  (rlast[1]),
        .m01_axi_rvalid (rvalid[1]),
        .m01_axi_rready (rready[1]),
        .m20_axi_rdata  (rdata[2]),
        .m20_axi_rstrb  (rstrb[2]),
        .m20_axi_rlast  (rlast[2]),
        .m20_axi_rvalid (rvalid[2]),
        .m20_axi_rready (rready[2]),
        .m21_axi_rdata  (rdata[3]),
        .m21_axi_rstrb  (rstrb[3]),
        .m21_axi_rlast  (rlast[3]),
        .m21_axi_rvalid (rvalid[3]),
        .m21_axi_rready (rready[3])
    );

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Real-valued reference: value = w/128 * s, floor(x + 0.5), clamp to [-128,127].
    function automatic logic [127:0] model_scale(input logic [127:0] d, input logic [8:0] wt);
        logic [127:0] res;
        logic [7:0]   lane;
        logic [31:0]  rr;
        int           s, wi, r;
        wi = int'($signed(wt));
        for (int l = 0; l < 16; l++) begin
            lane = d[l*8 +: 8];
            s    = int'($signed(lane));
            r    = $rtoi($floor(real'(wi * s) / 128.0 + 0.5));
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
            rr = r;
            res[l*8 +: 8] = rr[7:0];
        end
        return res;
    endfunction

    always @(negedge clock) begin
        int out, max_out, idx;
        logic [131:0] e;
        if (!resetn) begin
            chk("rst_wready", wready, 1'b0);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("rst_out_ch%0d", c), {rvalid[c], rlast[c], rstrb[c], rdata[c]}, '0);
                pop_idx[c]  = acc_cnt;
                prev_v[c]   = 0;
                prev_pop[c] = 0;
            end
            model_run = 0;
        end else begin
            max_out = 0;
            for (int c = 0; c < 4; c++) begin
                out = acc_cnt - pop_idx[c];
                if (out > max_out) max_out = out;
            end
            chk("wready", wready, model_run && (max_out <= DEPTH));
            for (int c = 0; c < 4; c++) begin
                out = acc_cnt - pop_idx[c];
                if (prev_v[c] && !prev_pop[c])
                    chk($sformatf("hold_valid_ch%0d", c), rvalid[c], 1'b1);
                if (rvalid[c]) begin
                    if (out == 0) begin
                        chk($sformatf("spurious_ch%0d", c), rvalid[c], 1'b0);
                    end else begin
                        idx = pop_idx[c] & 4095;
                        e = {2'b00, bl[idx], bs[idx], model_scale(bd[idx], bwt[idx][c])};
                        chk($sformatf("beat_ch%0d", c), {2'b00, rlast[c], rstrb[c], rdata[c]}, e);
                    end
                end else begin
                    chk($sformatf("hidden_ch%0d", c), out <= 1, 1'b1);
                end
                prev_v[c]   = rvalid[c];
                prev_pop[c] = rvalid[c] && rready[c];
                if (rvalid[c] && rready[c] && out > 0) begin
                    if (c == 3) ch3_log[pops_total[3] & 255] = rdata[3];
                    if (rlast[c]) lasts_total[c]++;
                    pops_total[c]++;
                    pop_idx[c]++;
                end
            end
            if (wvalid && wready) begin
                idx      = acc_cnt & 4095;
                bd[idx]  = wdata;
                bwt[idx] = w;
                bs[idx]  = wstrb;
                bl[idx]  = wlast;
                acc_cnt++;
            end
            model_run = 1;
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_ready();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (wready) ok = 1;
        end
        step();
        chk("wready_timeout", ok, 1'b1);
    endtask

    task automatic drain(input int max_cycles);
        bit ok = 0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clock);
            ok = 1;
            for (int c = 0; c < 4; c++) if (acc_cnt != pop_idx[c]) ok = 0;
        end
        step();
        step();
        chk("drain_timeout", ok, 1'b1);
    endtask

    task automatic send_beat(input logic [127:0] d, input logic last, input logic strb);
        bit got = 0;
        wdata  = d;
        wlast  = last;
        wstrb  = strb;
        wvalid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (wready) got = 1;
            step();
        end
        wvalid = 1'b0;
        chk("send_timeout", got, 1'b1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int p0 [4];
        int l0 [4];
        int n_acc, base;
        bit got, ok;
        logic [127:0] d;

        wvalid = 0; wdata = '0; wstrb = 0; wlast = 0; rready = 4'hF;
        w = {4{9'h040}};

        chk("pin_half",      model_scale({16{8'h40}}, 9'h040), {16{8'h20}});
        chk("pin_sat_hi",    model_scale({16{8'h7F}}, 9'h0C0), {16{8'h7F}});
        chk("pin_sat_lo",    model_scale({16{8'h80}}, 9'h0C0), {16{8'h80}});
        chk("pin_neg_round", model_scale({16{8'hFD}}, 9'h040), {16{8'hFF}});
        chk("pin_halve_10",  model_scale({16{8'h10}}, 9'h040), {16{8'h08}});

        repeat (3) @(posedge clock);
        #2 resetn = 1'b1;
        wait_ready();

        // 1: half weights, back-to-back beats, latency of one stage
        for (int c = 0; c < 4; c++) p0[c] = pops_total[c];
        wdata = {16{8'h40}}; wvalid = 1'b1;
        @(posedge clock); #1 chk("t1_lat_edge_k", rvalid, 4'h0);
        @(posedge clock); #1 chk("t1_lat_edge_k1", rvalid, 4'hF);
        for (int c = 0; c < 4; c++) chk($sformatf("t1_lane_ch%0d", c), rdata[c], {16{8'h20}});
        @(posedge clock); #1;
        @(posedge clock); #1;
        #1 wvalid = 1'b0;
        drain(20);
        for (int c = 0; c < 4; c++) chk($sformatf("t1_count_ch%0d", c), pops_total[c] - p0[c], 4);

        // 2: saturation and negative rounding
        w = {9'h1C0, 9'h080, 9'h040, 9'h0C0};
        rready = 4'h0;
        d = rnd128();
        d[7:0] = 8'h7F; d[15:8] = 8'h80; d[23:16] = 8'hFD;
        send_beat(d, 1'b0, 1'b0);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clock);
            if (rvalid[0] && rvalid[1]) ok = 1;
        end
        chk("t2_valid_timeout", ok, 1'b1);
        chk("t2_sat_hi", rdata[0][7:0], 8'h7F);
        chk("t2_sat_lo", rdata[0][15:8], 8'h80);
        chk("t2_neg_round", rdata[1][23:16], 8'hFF);
        step();
        rready = 4'hF;
        drain(20);

        // 3: stalled channel 20
        for (int c = 0; c < 4; c++) p0[c] = pops_total[c];
        rready = 4'b1011;
        n_acc = 0; wvalid = 1'b1; wdata = rnd128(); wlast = 0; wstrb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            got = wready && wvalid;
            if (got) n_acc++;
            step();
            if (got) wdata = rnd128();
            if (n_acc == 6) wvalid = 1'b0;
        end
        chk("t3_accepts", n_acc, 3);
        chk("t3_wready_low", wready, 1'b0);
        chk("t3_ch00_count", pops_total[0] - p0[0], 2);
        chk("t3_ch20_count", pops_total[2] - p0[2], 0);
        chk("t3_ch21_count", pops_total[3] - p0[3], 2);
        rready = 4'hF;
        for (int i = 0; i < 40 && n_acc < 6; i++) begin
            @(negedge clock);
            got = wready && wvalid;
            if (got) n_acc++;
            step();
            if (got) wdata = rnd128();
            if (n_acc == 6) wvalid = 1'b0;
        end
        wvalid = 1'b0;
        chk("t3_all_accepted", n_acc, 6);
        drain(30);
        for (int c = 0; c < 4; c++) chk($sformatf("t3_total_ch%0d", c), pops_total[c] - p0[c], 6);

        // 4: frame marker and strobe pass-through
        for (int c = 0; c < 4; c++) begin p0[c] = pops_total[c]; l0[c] = lasts_total[c]; end
        for (int i = 0; i < 4; i++) send_beat(rnd128(), i == 3, 1'b1);
        drain(20);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("t4_beats_ch%0d", c), pops_total[c] - p0[c], 4);
            chk($sformatf("t4_lasts_ch%0d", c), lasts_total[c] - l0[c], 1);
        end

        // 5: weight change mid-stream on channel 21
        w = {4{9'h080}};
        base = pops_total[3];
        send_beat({16{8'h10}}, 1'b0, 1'b0);
        send_beat({16{8'h10}}, 1'b0, 1'b0);
        w[3] = 9'h040;
        send_beat({16{8'h10}}, 1'b0, 1'b0);
        send_beat({16{8'h10}}, 1'b0, 1'b0);
        drain(20);
        chk("t5_count", pops_total[3] - base, 4);
        chk("t5_beat0", ch3_log[(base + 0) & 255], {16{8'h10}});
        chk("t5_beat1", ch3_log[(base + 1) & 255], {16{8'h10}});
        chk("t5_beat2", ch3_log[(base + 2) & 255], {16{8'h08}});
        chk("t5_beat3", ch3_log[(base + 3) & 255], {16{8'h08}});

        // 6: reset while full
        rready = 4'h0;
        wvalid = 1'b1; wdata = rnd128();
        repeat (6) step();
        chk("t6_full_wready", wready, 1'b0);
        chk("t6_full_valid", rvalid, 4'hF);
        resetn = 1'b0;
        wvalid = 1'b0;
        #1;
        chk("t6_rst_valid", rvalid, 4'h0);
        chk("t6_rst_wready", wready, 1'b0);
        for (int c = 0; c < 4; c++) chk($sformatf("t6_rst_data_ch%0d", c), rdata[c], '0);
        repeat (2) @(posedge clock);
        #2 resetn = 1'b1;
        rready = 4'hF;
        wait_ready();
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1 chk("t6_no_stale", rvalid, 4'h0);
        end
        #1;

        // random traffic, weights and backpressure
        for (int i = 0; i < 1500; i++) begin
            int k;
            wvalid = ($urandom_range(0, 3) != 0);
            wdata  = rnd128();
            wlast  = 1'($urandom_range(0, 1));
            wstrb  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, 3);
                w[k] = 9'($urandom_range(0, 511));
            end
            for (int c = 0; c < 4; c++) rready[c] = ($urandom_range(0, 3) != 0);
            if (i >= 500 && i < 700) rready[1] = 1'b0;
            step();
        end
        wvalid = 1'b0;
        rready = 4'hF;
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
